// File: rtl/qam_pkg.sv
// Shared defaults and types for the QAM sample deserializer.
// bit_pos maps the in-word bit counter to a sample bit index for either bit order.
package qam_pkg;
  localparam int SAMPLE_W_DEF = 8;
  localparam int DEPTH_DEF    = 4;

  typedef logic signed [SAMPLE_W_DEF-1:0] sample_t;

  function automatic int bit_pos(input int cnt, input logic lsb, input int w);
    return lsb ? cnt : (w - 1 - cnt);
  endfunction
endpackage

// File: rtl/qam_sample_deser_if.sv
// Serial bit stream in, sample valid/ready stream out.
// The slave modport is the deserializer side.
interface qam_sample_deser_if #(
  parameter int SAMPLE_W = 8,
  parameter int DEPTH    = 4
);
  logic                          bit_in;
  logic                          bit_en;
  logic                          bit_last;
  logic                          lsb_first;
  logic signed [SAMPLE_W-1:0]    sample_out;
  logic                          sample_valid;
  logic                          sample_ready;
  logic [$clog2(DEPTH+1)-1:0]    fifo_count;

  modport slave (
    input  bit_in, bit_en, bit_last, lsb_first, sample_ready,
    output sample_out, sample_valid, fifo_count
  );

  modport master (
    output bit_in, bit_en, bit_last, lsb_first, sample_ready,
    input  sample_out, sample_valid, fifo_count
  );
endinterface

// File: rtl/qam_sample_fifo.sv
// Synchronous FIFO; a push while full is accepted only when a pop occurs in the same cycle.
// dout reads as zero while empty so the sample output is clean out of reset.
module qam_sample_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = $clog2(DEPTH+1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);
  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr;
  logic [AW-1:0] r_rd;
  logic [CW-1:0] r_count;
  logic          w_push_ok;
  logic          w_pop_ok;

  assign empty     = (r_count == '0);
  assign full      = (r_count == CW'(DEPTH));
  assign count     = r_count;
  assign dout      = empty ? '0 : r_mem[r_rd];
  assign w_pop_ok  = pop && !empty;
  assign w_push_ok = push && (!full || w_pop_ok);

  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wr] <= din;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_push_ok) r_wr <= r_wr + AW'(1);
      if (w_pop_ok)  r_rd <= r_rd + AW'(1);
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

// File: rtl/qam_sample_deser.sv
// Serial-to-parallel sample deserializer: bit assembly, framing check and sticky flags,
// feeding a small output FIFO behind a valid/ready handshake.
module qam_sample_deser
  import qam_pkg::*;
#(
  parameter int SAMPLE_W = SAMPLE_W_DEF,
  parameter int DEPTH    = DEPTH_DEF,
  parameter int USE_LAST = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  qam_sample_deser_if.slave    bus,
  output logic                 overflow,
  output logic                 frame_err,
  input  logic                 err_clr
);
  localparam int CNT_W = $clog2(SAMPLE_W);

  logic [CNT_W-1:0]    r_cnt;
  logic [SAMPLE_W-1:0] r_word;
  logic                r_lsb;
  logic                r_ovf;
  logic                r_ferr;

  logic                w_lsb;
  int                  w_pos;
  logic [SAMPLE_W-1:0] w_word;
  logic                w_last_pos;
  logic                w_complete;
  logic                w_ferr_set;
  logic                w_ovf_set;
  logic                w_pop;
  logic                w_full;
  logic                w_empty;
  logic [SAMPLE_W-1:0] w_dout;

  // Bit order comes from the pin only on the first bit; later bits reuse the latched order.
  always_comb begin
    w_lsb  = (r_cnt == '0) ? bus.lsb_first : r_lsb;
    w_pos  = bit_pos(int'(r_cnt), w_lsb, SAMPLE_W);
    w_word = (r_cnt == '0) ? '0 : r_word;
    for (int i = 0; i < SAMPLE_W; i++) begin
      if (i == w_pos) w_word[i] = bus.bit_in;
    end
  end

  assign w_last_pos = (r_cnt == CNT_W'(SAMPLE_W-1));
  assign w_complete = bus.bit_en && w_last_pos && ((USE_LAST == 0) || bus.bit_last);
  assign w_ferr_set = (USE_LAST != 0) && bus.bit_en && (bus.bit_last != w_last_pos);
  assign w_pop      = !w_empty && bus.sample_ready;
  assign w_ovf_set  = w_complete && w_full && !w_pop;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt  <= '0;
      r_word <= '0;
      r_lsb  <= 1'b1;
      r_ovf  <= 1'b0;
      r_ferr <= 1'b0;
    end else begin
      if (bus.bit_en) begin
        r_word <= w_word;
        r_lsb  <= w_lsb;
        r_cnt  <= (w_last_pos || w_ferr_set) ? '0 : r_cnt + CNT_W'(1);
      end
      if (w_ovf_set)    r_ovf <= 1'b1;
      else if (err_clr) r_ovf <= 1'b0;
      if (w_ferr_set)   r_ferr <= 1'b1;
      else if (err_clr) r_ferr <= 1'b0;
    end
  end

  qam_sample_fifo #(.W(SAMPLE_W), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_complete),
    .pop   (w_pop),
    .din   (w_word),
    .dout  (w_dout),
    .count (bus.fifo_count),
    .full  (w_full),
    .empty (w_empty)
  );

  assign bus.sample_out   = $signed(w_dout);
  assign bus.sample_valid = !w_empty;
  assign overflow         = r_ovf;
  assign frame_err        = r_ferr;
endmodule

// File: doc/qam_sample_deser.md
# qam_sample_deser

Parametrised serial-to-parallel sample deserializer for the QAM modulation datapath. It takes the modulator's serial amplitude bit stream and its word-complete strobe, and reassembles signed SAMPLE_W-bit samples. Bit order is selectable, framing errors are detected, and completed samples are buffered in a small FIFO behind a valid/ready handshake. It sits directly downstream of the modulator's serial output and replaces ad-hoc capture counters in benches and downstream DSP.

## Interface
- SAMPLE_W, 8: sample width in bits, ≥2; samples are two's complement.
- DEPTH, 4: output FIFO depth in words, ≥2, power of two.
- USE_LAST, 1: 1 = word boundary from bit_last; 0 = free-running SAMPLE_W-bit count, bit_last ignored.

Ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- bit_in  in  1  serial sample bit.
- bit_en  in  1  bit_in valid this cycle.
- bit_last  in  1  qualified by bit_en; marks final bit of a sample.
- lsb_first  in  1  bit order for the word being assembled.
- sample_out  out  SAMPLE_W  FIFO head, signed.
- sample_valid  out  1  FIFO not empty.
- sample_ready  in  1  consumer accepts head.
- fifo_count  out  $clog2(DEPTH+1)  words held.
- overflow  out  1  sticky; a completed word was dropped.
- frame_err  out  1  sticky; framing mismatch.
- err_clr  in  1  clears both sticky flags.

## Operation
- Bit counter cnt runs 0..SAMPLE_W-1. Each bit_en cycle writes bit_in to position cnt (LSB-first) or SAMPLE_W-1-cnt (MSB-first).
- lsb_first is latched when a bit is accepted with cnt==0 and held for the rest of that word. Changes mid-word have no effect.
- USE_LAST=0: the word completes on the bit with cnt==SAMPLE_W-1, then cnt wraps to 0.
- USE_LAST=1:
  - cnt==SAMPLE_W-1 with bit_last=1: word completes.
  - bit_last=1 with cnt<SAMPLE_W-1: frame_err set, partial word discarded, cnt←0.
  - cnt==SAMPLE_W-1 with bit_last=0: frame_err set, word discarded, cnt←0.
- Completion pushes the word, including the incoming bit, into the FIFO.
- Push rules:
  - Push is accepted if FIFO not full, or if full and a pop happens the same cycle.
  - Otherwise the word is dropped and overflow is set.
- Pop occurs when sample_valid && sample_ready.
- Simultaneous push and pop: fifo_count is unchanged and order is preserved.
- err_clr clears the flags; a set event in the same cycle wins.
- FIFO contents never depend on flags. Flags never block operation.

## Timing
- Reset (rst low, asynchronous): cnt=0, FIFO empty, sample_valid=0, sample_out=0, fifo_count=0, overflow=0, frame_err=0, latched order=LSB-first.
- Reset mid-word discards the partial word. The first bit_en after release is bit 0.
- Latency: completing bit accepted at edge N → sample_valid=1 and sample_out valid after edge N, when the FIFO was empty.
- sample_out is stable while sample_valid && !sample_ready.
- After a pop at edge N, the next word appears after edge N.
- Throughput: one bit per cycle sustained. A new word can begin the cycle after completion.
- Flags update at the edge of the causing event.

## Structure
- Shared package qam_pkg holds the SAMPLE_W/DEPTH defaults and a sample typedef (signed [SAMPLE_W-1:0]).
- One sub-module, qam_sample_fifo: synchronous FIFO with push, pop, count, full, and empty.
- The assembler, counter, and framing logic stay in the top.

## Test plan
- LSB-first 0xA5 sent as 1,0,1,0,0,1,0,1 with bit_last on the 8th bit → sample_out=-91, sample_valid rises after the 8th edge, frame_err=0.
- MSB-first 0x7F sent as 0,1,1,1,1,1,1,1, with USE_LAST=0 and bit_last held 0 → sample_out=+127.
- sample_ready=0, push 5 words 1..5 → fifo_count=4, overflow=1. Then drain → 1,2,3,4 in order.
- FIFO full, word completes in the same cycle as a pop → no overflow, fifo_count stays 4.
- USE_LAST=1, bit_last on the 5th bit → frame_err=1, nothing pushed. Next 8 bits of 0x80 with bit_last on the 8th → -128. err_clr → frame_err=0.
- 3 bits in, rst low for 2 cycles → all outputs reset. A full 0x01 word after release → +1.
